// File: rtl/regfile_write_scheduler_if.sv
// Write-request bus between the two writeback requesters and the
// register-file write scheduler, plus the register-file write port.
interface regfile_write_scheduler_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              WE3;
  logic [ADDR_W-1:0] WA3;
  logic [DATA_W-1:0] WD3;

  // Requester side: offers writes, observes acceptance and the write port.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  WE3, WA3, WD3
  );

  // Scheduler side: accepts writes and drives the register-file write port.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output WE3, WA3, WD3
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Single write-port owner for the 32x32 register file.
// After reset (or a clear request) it zero-fills x1..x31, one register per
// cycle, then arbitrates round-robin between the ALU (req0) and the load
// unit (req1). Grants are combinational; the write port is registered, so
// an accepted write appears on WE3/WA3/WD3 one edge later.
module regfile_write_scheduler #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_req,
  output logic                   busy,
  regfile_write_scheduler_if.slave bus
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic              rr_last;    // index of the requester that won last
  logic              grant0;
  logic              grant1;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: sweep ends after the last register, clear restarts it.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR: begin
        if (ptr == LAST_PTR) begin
          state_next = RUN;
        end else begin
          state_next = CLEAR;
        end
      end
      RUN: begin
        if (clear_req) begin
          state_next = CLEAR;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // FSM outputs: busy flag and round-robin grant (clear beats any request).
  always_comb begin
    busy   = 1'b0;
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
      end
      RUN: begin
        if (clear_req) begin
          grant0 = 1'b0;
          grant1 = 1'b0;
        end else if (bus.req0_valid && bus.req1_valid) begin
          // Favour whichever requester did not win last.
          grant0 = rr_last;
          grant1 = ~rr_last;
        end else begin
          grant0 = bus.req0_valid;
          grant1 = bus.req1_valid;
        end
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign win_addr       = grant1 ? bus.req1_addr : bus.req0_addr;
  assign win_data       = grant1 ? bus.req1_data : bus.req0_data;

  // Sweep pointer and round-robin history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr     <= FIRST_PTR;
      rr_last <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ptr + ADDR_W'(1);
        end
        RUN: begin
          if (clear_req) begin
            ptr <= FIRST_PTR;
          end else begin
            ptr <= ptr;
          end
          if (grant0) begin
            rr_last <= 1'b0;
          end else if (grant1) begin
            rr_last <= 1'b1;
          end else begin
            rr_last <= rr_last;
          end
        end
        default: begin
          ptr <= FIRST_PTR;
        end
      endcase
    end
  end

  // Registered write port: sweep zeros, or the winner's write; x0 never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else if (state == CLEAR) begin
      we3 <= 1'b1;
      wa3 <= ptr;
      wd3 <= '0;
    end else if (grant0 || grant1) begin
      if (win_addr != '0) begin
        we3 <= 1'b1;
        wa3 <= win_addr;
        wd3 <= win_data;
      end else begin
        we3 <= 1'b0;
      end
    end else begin
      we3 <= 1'b0;
    end
  end

  assign bus.WE3 = we3;
  assign bus.WA3 = wa3;
  assign bus.WD3 = wd3;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against
// a behavioural model (sweep countdown + last-winner memory).
module tb_regfile_write_scheduler;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic clear_req = 1'b0;
  logic busy;

  regfile_write_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_write_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(NREGS)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int               m_left;   // sweep writes still to issue
  int               m_last;   // requester that won most recently
  logic             m_we;
  logic [ADDR_W-1:0] m_wa;
  logic [DATA_W-1:0] m_wd;
  logic             m_acc0;
  logic             m_acc1;

  // Who gets the port this cycle: -1 none, 0 or 1.
  function automatic int pick(input int left, input int last, input logic clr,
                              input logic v0, input logic v1);
    if (left != 0 || clr) return -1;
    if (v0 && v1) return 1 - last;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Model advance on each clock edge, reset asynchronously like the design.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= NREGS - 1;
      m_last <= 1;
      m_we   <= 1'b0;
      m_wa   <= '0;
      m_wd   <= '0;
      m_acc0 <= 1'b0;
      m_acc1 <= 1'b0;
    end else if (m_left != 0) begin
      m_we   <= 1'b1;
      m_wa   <= ADDR_W'(NREGS - m_left);
      m_wd   <= '0;
      m_left <= m_left - 1;
      m_acc0 <= 1'b0;
      m_acc1 <= 1'b0;
    end else if (clear_req) begin
      m_we   <= 1'b0;
      m_left <= NREGS - 1;
      m_acc0 <= 1'b0;
      m_acc1 <= 1'b0;
    end else if (pick(m_left, m_last, clear_req, bus.req0_valid, bus.req1_valid) == 0) begin
      m_acc0 <= 1'b1;
      m_acc1 <= 1'b0;
      m_last <= 0;
      m_we   <= (bus.req0_addr != '0);
      if (bus.req0_addr != '0) begin
        m_wa <= bus.req0_addr;
        m_wd <= bus.req0_data;
      end
    end else if (pick(m_left, m_last, clear_req, bus.req0_valid, bus.req1_valid) == 1) begin
      m_acc0 <= 1'b0;
      m_acc1 <= 1'b1;
      m_last <= 1;
      m_we   <= (bus.req1_addr != '0);
      if (bus.req1_addr != '0) begin
        m_wa <= bus.req1_addr;
        m_wd <= bus.req1_data;
      end
    end else begin
      m_we   <= 1'b0;
      m_acc0 <= 1'b0;
      m_acc1 <= 1'b0;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_left != 0));
      check("req0_ready", 32'(bus.req0_ready),
            32'(pick(m_left, m_last, clear_req, bus.req0_valid, bus.req1_valid) == 0));
      check("req1_ready", 32'(bus.req1_ready),
            32'(pick(m_left, m_last, clear_req, bus.req0_valid, bus.req1_valid) == 1));
      check("WE3", 32'(bus.WE3), 32'(m_we));
      check("WA3", 32'(bus.WA3), 32'(m_wa));
      check("WD3", bus.WD3, m_wd);
    end
  end

  function automatic logic [ADDR_W-1:0] rnd_addr();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return '0;
    if (r < 4) return ADDR_W'($urandom_range(1, 3));
    return ADDR_W'($urandom_range(1, NREGS - 1));
  endfunction

  // Stimulus: directed scenarios, random traffic, reset in mid-sweep.
  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_data  = '0;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_WE3", 32'(bus.WE3), 32'd0);
    check("reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;

    // Post-reset sweep x1..x31.
    for (int i = 1; i <= NREGS - 1; i++) begin
      @(posedge clk); #1;
      check("sweep_we", 32'(bus.WE3), 32'd1);
      check("sweep_wa", 32'(bus.WA3), 32'(i));
      check("sweep_wd", bus.WD3, 32'd0);
      check("sweep_busy", 32'(busy), (i < NREGS - 1) ? 32'd1 : 32'd0);
    end

    // Single requester.
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'd6;
    #1;
    check("single_ready0", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    check("single_we", 32'(bus.WE3), 32'd1);
    check("single_wa", 32'(bus.WA3), 32'd5);
    check("single_wd", bus.WD3, 32'd6);

    // Both valid: req0 won last, so alternation starts with req1.
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h0000_000A;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd4; bus.req1_data = 32'h0000_000B;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("rr_wa", 32'(bus.WA3), (k % 2 == 0) ? 32'd4 : 32'd3);
      check("rr_wd", bus.WD3, (k % 2 == 0) ? 32'h0000_000B : 32'h0000_000A);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_we", 32'(bus.WE3), 32'd0);
    check("idle_wa_hold", 32'(bus.WA3), 32'd3);
    check("idle_wd_hold", bus.WD3, 32'h0000_000A);

    // Write to x0 is accepted but suppressed.
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'hFFFF_FFFF;
    #1;
    check("x0_ready1", 32'(bus.req1_ready), 32'd1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    check("x0_we", 32'(bus.WE3), 32'd0);

    // Clear request beats a pending write; write lands after the sweep.
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'h0000_0077;
    clear_req = 1'b1;
    #1;
    check("clr_ready0", 32'(bus.req0_ready), 32'd0);
    @(posedge clk); #1;
    clear_req = 1'b0;
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_we", 32'(bus.WE3), 32'd0);
    for (int i = 1; i <= NREGS - 1; i++) begin
      @(posedge clk); #1;
      check("clr_sweep_wa", 32'(bus.WA3), 32'(i));
    end
    check("clr_after_ready0", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    check("clr_after_wa", 32'(bus.WA3), 32'd7);
    check("clr_after_wd", bus.WD3, 32'h0000_0077);

    // Randomized traffic with occasional clears and resets.
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      if (!reset) begin
        reset = 1'b1;
      end else if ($urandom_range(0, 249) == 0) begin
        reset = 1'b0;
      end
      clear_req = ($urandom_range(0, 39) == 0);
      if (!bus.req0_valid || m_acc0) begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        bus.req0_addr  = rnd_addr();
        bus.req0_data  = $urandom;
      end
      if (!bus.req1_valid || m_acc1) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_addr  = rnd_addr();
        bus.req1_data  = $urandom;
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    clear_req = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Reset at sweep pointer 10 restarts the sweep from x1.
    for (int t = 0; t < 40 && busy; t++) begin
      @(posedge clk); #1;
    end
    check("pre_clear_idle", 32'(busy), 32'd0);
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_sweep_wa9", 32'(bus.WA3), 32'd9);
    reset = 1'b0;
    #1;
    check("mid_rst_we", 32'(bus.WE3), 32'd0);
    check("mid_rst_wa", 32'(bus.WA3), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("restart_we", 32'(bus.WE3), 32'd1);
    check("restart_wa", 32'(bus.WA3), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
